// File: rtl/arb_pkg.sv
// Shared definitions for the SRAM bus arbiter: FSM state encoding and owner codes.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int GNT_INST = 0;
    localparam int GNT_DATA = 1;

endpackage

// File: rtl/arb_pick.sv
// Grant selection between the instruction and data requesters.
// Default build: data has fixed priority. ARB_ROUND_ROBIN_EN: ties go to the side not granted last.
module arb_pick
    import arb_pkg::*;
(
    input  logic       inst_req,
    input  logic       data_req,
    input  owner_e     last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req && data_req) begin
            grant[GNT_INST] = (last_grant == OWN_DATA);
            grant[GNT_DATA] = (last_grant == OWN_INST);
        end else begin
            grant[GNT_INST] = inst_req;
            grant[GNT_DATA] = data_req;
        end
`else
        if (data_req) begin
            grant[GNT_DATA] = 1'b1;
        end else if (inst_req) begin
            grant[GNT_INST] = 1'b1;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the grant history.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == OWN_DATA);
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates instruction and data SRAM-like ports onto one shared memory port, one transaction at a time.
// Tie-break policy selected by ARB_ROUND_ROBIN_EN (see arb_pick).
//
// state   | meaning
// IDLE    | no transaction; accept a request and pulse its addr_ok
// ADDR    | mem_req driven with latched fields, waiting for mem_addr_ok
// RESP    | waiting for mem_data_ok, routed to the owner
module sram_bus_arbiter
    import arb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [31:0]   inst_rdata,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [AW-1:0] data_addr,
    input  logic [31:0]   data_wdata,
    input  logic [3:0]    data_wstrb,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [31:0]   data_rdata,

    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [31:0]   mem_rdata
);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_q,  last_d;
    logic          wr_q,    wr_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [1:0]    grant;

    arb_pick u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 32'h0;
        mem_wstrb    = 4'h0;

        case (state_q)
            ST_IDLE: begin
                // addr_ok is combinational on the request, so hold it off while in reset
                inst_addr_ok = grant[GNT_INST] & resetn;
                data_addr_ok = grant[GNT_DATA] & resetn;
                if (grant[GNT_DATA]) begin
                    owner_d = OWN_DATA;
                    last_d  = OWN_DATA;
                    wr_d    = data_wr;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    wstrb_d = data_wstrb;
                    state_d = ST_ADDR;
                end else if (grant[GNT_INST]) begin
                    owner_d = OWN_INST;
                    last_d  = OWN_INST;
                    wr_d    = 1'b0;
                    addr_d  = inst_addr;
                    wdata_d = 32'h0;
                    wstrb_d = 4'h0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_req   = 1'b1;
                mem_wr    = wr_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wstrb = wstrb_q;
                if (mem_addr_ok) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_data_ok) begin
                    if (owner_q == OWN_DATA) begin
                        data_data_ok = 1'b1;
                        data_rdata   = wr_q ? 32'h0 : mem_rdata;
                    end else begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = mem_rdata;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_INST;
            last_q  <= OWN_INST;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter; honours ARB_ROUND_ROBIN_EN for the tie-break model.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [137:0] all_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_last_data;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    sram_bus_arbiter #(.AW(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    assign all_out = {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok,
                      data_rdata, mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arbitration rule: returns 1 when data should win.
    function automatic bit model_grant_data(input bit ri, input bit rd);
        bit gd;
        if (ri && rd) gd = RR_MODE ? !model_last_data : 1'b1;
        else          gd = rd;
        return gd;
    endfunction

    task automatic clear_inputs();
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        model_last_data = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 0;
        inst_req = 1; data_req = 1; data_wr = 1; mem_addr_ok = 1; mem_data_ok = 1;
        mem_rdata = $urandom;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h exp 0", all_out);
        end
        apply_reset();
        @(negedge clk); #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_idle_outputs: got %h exp 0", all_out);
        end
    endtask

    task automatic test_inst_fetch();
        apply_reset();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h1C000000;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h02800C0C;
        #1;
        n_checks++;
        if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL fetch_accept_T: got ok/dok/req %b%b%b exp 100", inst_addr_ok, data_addr_ok, mem_req);
        end
        @(negedge clk);
        inst_req = 0; inst_addr = $urandom;
        #1;
        n_checks++;
        if ({mem_req, mem_wr, mem_addr, mem_wstrb, inst_data_ok, inst_addr_ok} !== {1'b1, 1'b0, 32'h1C000000, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_mem_req_T1: got req %b wr %b addr %h strb %h dok %b exp 1 0 1c000000 0 0",
                     mem_req, mem_wr, mem_addr, mem_wstrb, inst_data_ok);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({inst_data_ok, inst_rdata, data_data_ok, mem_req} !== {1'b1, 32'h02800C0C, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_data_T2: got dok %b rdata %h ddok %b req %b exp 1 02800c0c 0 0",
                     inst_data_ok, inst_rdata, data_data_ok, mem_req);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({inst_data_ok, mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_back_idle: got dok %b req %b exp 0 0", inst_data_ok, mem_req);
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        logic [31:0] a_i, r;
        apply_reset();
        a_i = $urandom; r = $urandom;
        @(negedge clk);
        inst_req = 1; inst_addr = a_i;
        data_req = 1; data_wr = 0; data_addr = 32'h00001000;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = r;
        #1;
        n_checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_data_first: got dok/iok %b%b exp 10", data_addr_ok, inst_addr_ok);
        end
        @(negedge clk);
        data_req = 0;
        #1;
        n_checks++;
        if ({mem_req, mem_wr, mem_addr, inst_addr_ok} !== {1'b1, 1'b0, 32'h00001000, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_data_mem: got req %b wr %b addr %h iok %b exp 1 0 00001000 0",
                     mem_req, mem_wr, mem_addr, inst_addr_ok);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({data_data_ok, data_rdata, inst_data_ok, inst_addr_ok} !== {1'b1, r, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_data_resp: got ddok %b rdata %h idok %b iok %b exp 1 %h 0 0",
                     data_data_ok, data_rdata, inst_data_ok, inst_addr_ok, r);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_inst_next: got iok/dok %b%b exp 10", inst_addr_ok, data_addr_ok);
        end
        @(negedge clk);
        inst_req = 0;
        #1;
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, a_i}) begin
            n_fail++;
            $display("FAIL prio_inst_mem: got req %b addr %h exp 1 %h", mem_req, mem_addr, a_i);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, r, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_inst_resp: got dok %b rdata %h ddok %b exp 1 %h 0", inst_data_ok, inst_rdata, data_data_ok, r);
        end
        clear_inputs();
    endtask

    task automatic test_store_wait();
        apply_reset();
        @(negedge clk);
        data_req = 1; data_wr = 1; data_addr = 32'h00002004; data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF;
        mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        n_checks++;
        if (data_addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL store_accept: got %b exp 1", data_addr_ok);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            data_req = 0; data_addr = $urandom; data_wdata = $urandom; data_wstrb = 4'($urandom);
            mem_addr_ok = (c == 3);
            #1;
            n_checks++;
            if ({mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb, data_data_ok} !==
                {1'b1, 1'b1, 32'h00002004, 32'hDEADBEEF, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL store_hold_%0d: got req %b wr %b addr %h wdata %h strb %h ddok %b exp 1 1 00002004 deadbeef f 0",
                         c, mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb, data_data_ok);
            end
        end
        @(negedge clk);
        mem_addr_ok = 0; mem_data_ok = 0;
        #1;
        n_checks++;
        if ({data_data_ok, mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL store_resp_wait: got ddok %b req %b exp 0 0", data_data_ok, mem_req);
        end
        @(negedge clk);
        mem_data_ok = 1; mem_rdata = 32'hA5A5A5A5;
        #1;
        n_checks++;
        if ({data_data_ok, data_rdata, inst_data_ok} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL store_done: got ddok %b rdata %h idok %b exp 1 00000000 0", data_data_ok, data_rdata, inst_data_ok);
        end
        @(negedge clk); #1;
        n_checks++;
        if (data_data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL store_single_pulse: got %b exp 0", data_data_ok);
        end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        bit gd;
        apply_reset();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h00000100;
        data_req = 1; data_wr = 0; data_addr = 32'h00000200;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            gd = model_grant_data(1'b1, 1'b1);
            model_last_data = gd;
            #1;
            n_checks++;
            if ({data_addr_ok, inst_addr_ok} !== {gd, !gd}) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got dok/iok %b%b exp %b%b", k, data_addr_ok, inst_addr_ok, gd, !gd);
            end
            @(negedge clk); #1;
            n_checks++;
            if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, gd ? 32'h200 : 32'h100, 2'b00}) begin
                n_fail++;
                $display("FAIL rr_mem_%0d: got req %b addr %h oks %b%b", k, mem_req, mem_addr, inst_addr_ok, data_addr_ok);
            end
            @(negedge clk); #1;
            n_checks++;
            if ({data_data_ok, inst_data_ok} !== {gd, !gd}) begin
                n_fail++;
                $display("FAIL rr_resp_%0d: got ddok/idok %b%b exp %b%b", k, data_data_ok, inst_data_ok, gd, !gd);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        inst_req = 1; inst_addr = $urandom; mem_addr_ok = 1; mem_data_ok = 0;
        @(negedge clk);
        inst_req = 0;
        @(negedge clk); #1;
        n_checks++;
        if ({inst_data_ok, mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_in_resp: got dok %b req %b exp 0 0", inst_data_ok, mem_req);
        end
        @(negedge clk);
        resetn = 0; mem_data_ok = 1; mem_rdata = $urandom; inst_req = 1; data_req = 1;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h exp 0", all_out);
        end
        @(negedge clk);
        resetn = 1; inst_req = 0; data_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_rdata = $urandom;
            #1;
            n_checks++;
            if ({inst_data_ok, data_data_ok, mem_req} !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_spurious_%0d: got idok %b ddok %b req %b exp 0 0 0", c, inst_data_ok, data_data_ok, mem_req);
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit ri, rd, gd, wr;
        logic [31:0] ia, da, wd, exp_addr, rd_word;
        logic [3:0] ws;
        int aw, dw, r;
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(1, 3);
            ri = r[0]; rd = r[1];
            ia = $urandom; da = $urandom; wd = $urandom; ws = 4'($urandom); wr = 1'($urandom);
            aw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
            gd = model_grant_data(ri, rd);
            model_last_data = gd;
            exp_addr = gd ? da : ia;
            @(negedge clk);
            inst_req = ri; inst_addr = ia;
            data_req = rd; data_wr = wr; data_addr = da; data_wdata = wd; data_wstrb = ws;
            mem_addr_ok = 1'($urandom); mem_data_ok = 1'($urandom); mem_rdata = $urandom;
            #1;
            n_checks++;
            if ({data_addr_ok, inst_addr_ok} !== {gd, !gd}) begin
                n_fail++;
                $display("FAIL rnd_grant_%0d: got dok/iok %b%b exp %b%b", t, data_addr_ok, inst_addr_ok, gd, !gd);
            end
            for (int c = 0; c <= aw; c++) begin
                @(negedge clk);
                inst_req = 1'($urandom); data_req = 1'($urandom); inst_addr = $urandom; data_addr = $urandom;
                data_wr = 1'($urandom); data_wdata = $urandom; data_wstrb = 4'($urandom);
                mem_addr_ok = (c == aw); mem_data_ok = 1'($urandom);
                #1;
                n_checks++;
                if ({mem_req, mem_wr, mem_addr, mem_wstrb, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !==
                    {1'b1, gd & wr, exp_addr, gd ? ws : 4'h0, 4'b0000} ||
                    (gd && mem_wdata !== wd)) begin
                    n_fail++;
                    $display("FAIL rnd_addr_%0d: got req %b wr %b addr %h strb %h wdata %h exp 1 %b %h %h %h",
                             t, mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata, gd & wr, exp_addr, gd ? ws : 4'h0, wd);
                end
            end
            for (int c = 0; c <= dw; c++) begin
                @(negedge clk);
                inst_req = 1'($urandom); data_req = 1'($urandom);
                mem_addr_ok = 1'($urandom); mem_data_ok = (c == dw);
                rd_word = $urandom; mem_rdata = rd_word;
                #1;
                if (c == dw) begin
                    n_checks++;
                    if ({data_data_ok, inst_data_ok} !== {gd, !gd} ||
                        data_rdata !== ((gd && !wr) ? rd_word : 32'h0) ||
                        inst_rdata !== (gd ? 32'h0 : rd_word) ||
                        {mem_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin
                        n_fail++;
                        $display("FAIL rnd_resp_%0d: got ddok %b idok %b drdata %h irdata %h req %b exp %b %b %h %h 0",
                                 t, data_data_ok, inst_data_ok, data_rdata, inst_rdata, mem_req, gd, !gd,
                                 (gd && !wr) ? rd_word : 32'h0, gd ? 32'h0 : rd_word);
                    end
                end else begin
                    n_checks++;
                    if ({data_data_ok, inst_data_ok, mem_req, inst_addr_ok, data_addr_ok} !== 5'b00000) begin
                        n_fail++;
                        $display("FAIL rnd_wait_%0d: got ddok %b idok %b req %b iok %b dok %b exp all 0",
                                 t, data_data_ok, inst_data_ok, mem_req, inst_addr_ok, data_addr_ok);
                    end
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        resetn = 1;
        clear_inputs();
        model_last_data = 0;
        test_reset();
        test_inst_fetch();
        test_priority();
        test_store_wait();
        test_round_robin();
        test_reset_mid();
        test_random();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
